// File: rtl/mem_march_bist.sv
// mem_march_bist: March-test requester for the single-port memory.
// Runs up w(P); up r(P) w(~P); down r(~P) w(P); down r(P) and records the first miscompare.
module mem_march_bist #(
    parameter int Data_Width    = 32,
    parameter int Address_Width = 5,
    parameter int Locations_Num = 32,
    parameter int Timeout       = 15
) (
    input  logic                     CLK,
    input  logic                     Rst,
    input  logic                     Start,
    input  logic [Data_Width-1:0]    Pattern,
    output logic                     Wr_En,
    output logic                     Rd_En,
    output logic [Address_Width-1:0] Address,
    output logic [Data_Width-1:0]    Data_in,
    input  logic [Data_Width-1:0]    Data_out,
    input  logic                     Valid_out,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Pass,
    output logic [7:0]               Err_Count,
    output logic [Address_Width-1:0] Fail_Addr,
    output logic [Data_Width-1:0]    Fail_Exp,
    output logic [Data_Width-1:0]    Fail_Got,
    output logic                     Timeout_Err
);
    localparam int TW = (Timeout > 1) ? $clog2(Timeout) : 1;
    localparam logic [TW-1:0]            WAIT_LAST = TW'(Timeout - 1);
    localparam logic [Address_Width-1:0] ADDR_LAST = Address_Width'(Locations_Num - 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ_REQ, READ_WAIT, DONE} state_t;
    typedef enum logic [1:0] {M0, M1, M2, M3} elem_t;

    state_t                r_state;
    elem_t                 r_elem;
    logic [Data_Width-1:0] r_pat;
    logic [TW-1:0]         r_wait;

    logic [Data_Width-1:0] w_exp;
    logic [Data_Width-1:0] w_wdata;
    logic                  w_mismatch;
    logic [7:0]            w_err_next;
    logic                  w_addr_last;
    logic                  w_addr_first;

    always_comb begin
        w_exp        = (r_elem == M2) ? ~r_pat : r_pat;
        w_wdata      = (r_elem == M1) ? ~r_pat : r_pat;
        w_mismatch   = (Data_out != w_exp);
        w_err_next   = (w_mismatch && (Err_Count != '1)) ? Err_Count + 8'd1 : Err_Count;
        w_addr_last  = (Address == ADDR_LAST);
        w_addr_first = (Address == '0);
    end

    // Strobes, address and data are registered: each transition sets them for the state it enters.
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            r_state     <= IDLE;
            r_elem      <= M0;
            r_pat       <= '0;
            r_wait      <= '0;
            Wr_En       <= 1'b0;
            Rd_En       <= 1'b0;
            Address     <= '0;
            Data_in     <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Pass        <= 1'b0;
            Err_Count   <= '0;
            Fail_Addr   <= '0;
            Fail_Exp    <= '0;
            Fail_Got    <= '0;
            Timeout_Err <= 1'b0;
        end else begin
            Wr_En <= 1'b0;
            Rd_En <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (Start) begin
                        r_pat       <= Pattern;
                        r_elem      <= M0;
                        Err_Count   <= '0;
                        Fail_Addr   <= '0;
                        Fail_Exp    <= '0;
                        Fail_Got    <= '0;
                        Timeout_Err <= 1'b0;
                        Done        <= 1'b0;
                        Pass        <= 1'b0;
                        Busy        <= 1'b1;
                        Address     <= '0;
                        Data_in     <= Pattern;
                        Wr_En       <= 1'b1;
                        r_state     <= WRITE;
                    end
                end
                WRITE: begin
                    case (r_elem)
                        M0: begin
                            if (w_addr_last) begin
                                r_elem  <= M1;
                                Address <= '0;
                                Rd_En   <= 1'b1;
                                r_state <= READ_REQ;
                            end else begin
                                Address <= Address + Address_Width'(1);
                                Data_in <= r_pat;
                                Wr_En   <= 1'b1;
                            end
                        end
                        M1: begin
                            if (w_addr_last) begin
                                r_elem  <= M2;
                                Address <= ADDR_LAST;
                            end else begin
                                Address <= Address + Address_Width'(1);
                            end
                            Rd_En   <= 1'b1;
                            r_state <= READ_REQ;
                        end
                        default: begin
                            if (w_addr_first) begin
                                r_elem  <= M3;
                                Address <= ADDR_LAST;
                            end else begin
                                Address <= Address - Address_Width'(1);
                            end
                            Rd_En   <= 1'b1;
                            r_state <= READ_REQ;
                        end
                    endcase
                end
                READ_REQ: begin
                    r_wait  <= '0;
                    r_state <= READ_WAIT;
                end
                READ_WAIT: begin
                    if (Valid_out) begin
                        Err_Count <= w_err_next;
                        if (w_mismatch && (Err_Count == '0)) begin
                            Fail_Addr <= Address;
                            Fail_Exp  <= w_exp;
                            Fail_Got  <= Data_out;
                        end
                        if (r_elem == M3) begin
                            if (w_addr_first) begin
                                Busy    <= 1'b0;
                                Done    <= 1'b1;
                                Pass    <= (w_err_next == '0);
                                r_state <= DONE;
                            end else begin
                                Address <= Address - Address_Width'(1);
                                Rd_En   <= 1'b1;
                                r_state <= READ_REQ;
                            end
                        end else begin
                            Data_in <= w_wdata;
                            Wr_En   <= 1'b1;
                            r_state <= WRITE;
                        end
                    end else if (r_wait == WAIT_LAST) begin
                        Timeout_Err <= 1'b1;
                        Busy        <= 1'b0;
                        Done        <= 1'b1;
                        Pass        <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        r_wait <= r_wait + TW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_march_bist.sv
// tb_mem_march_bist: drives mem_march_bist against a latency-configurable faulty memory
// and checks every cycle against an operation-list model of the March test.
module tb_mem_march_bist;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int N   = 32;
    localparam int TMO = 15;

    logic          CLK;
    logic          Rst;
    logic          Start;
    logic [DW-1:0] Pattern;
    logic          Wr_En;
    logic          Rd_En;
    logic [AW-1:0] Address;
    logic [DW-1:0] Data_in;
    logic [DW-1:0] Data_out;
    logic          Valid_out;
    logic          Busy;
    logic          Done;
    logic          Pass;
    logic [7:0]    Err_Count;
    logic [AW-1:0] Fail_Addr;
    logic [DW-1:0] Fail_Exp;
    logic [DW-1:0] Fail_Got;
    logic          Timeout_Err;

    mem_march_bist #(
        .Data_Width(DW), .Address_Width(AW), .Locations_Num(N), .Timeout(TMO)
    ) dut (
        .CLK(CLK), .Rst(Rst), .Start(Start), .Pattern(Pattern),
        .Wr_En(Wr_En), .Rd_En(Rd_En), .Address(Address), .Data_in(Data_in),
        .Data_out(Data_out), .Valid_out(Valid_out),
        .Busy(Busy), .Done(Done), .Pass(Pass), .Err_Count(Err_Count),
        .Fail_Addr(Fail_Addr), .Fail_Exp(Fail_Exp), .Fail_Got(Fail_Got),
        .Timeout_Err(Timeout_Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Memory environment: read latency, stuck-at fault, suppressed or spurious Valid_out.
    int            lat = 1;
    bit            kill = 1'b0;
    bit            noise = 1'b0;
    int            f_addr = 0;
    logic [DW-1:0] f_or = '0;
    logic [DW-1:0] f_and = '0;
    logic [DW-1:0] mem [N];
    logic [DW-1:0] pdata;
    int            cnt;

    function automatic logic [DW-1:0] faulty(input int a, input logic [DW-1:0] v,
                                             input int fa, input logic [DW-1:0] fo,
                                             input logic [DW-1:0] fz);
        return (a == fa) ? ((v | fo) & ~fz) : v;
    endfunction

    always @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            cnt       <= 0;
            Valid_out <= 1'b0;
            Data_out  <= '0;
        end else begin
            if (Wr_En) mem[Address] <= Data_in;
            if (Rd_En) begin
                if (lat == 1) begin
                    Valid_out <= !kill;
                    Data_out  <= faulty(int'(Address), mem[Address], f_addr, f_or, f_and);
                    cnt       <= 0;
                end else begin
                    Valid_out <= 1'b0;
                    cnt       <= lat - 1;
                    pdata     <= faulty(int'(Address), mem[Address], f_addr, f_or, f_and);
                end
            end else if (cnt == 1) begin
                cnt       <= 0;
                Valid_out <= !kill;
                Data_out  <= pdata;
            end else if (cnt > 1) begin
                cnt       <= cnt - 1;
                Valid_out <= 1'b0;
            end else begin
                Valid_out <= noise && !kill && ($urandom_range(0, 3) == 0);
                Data_out  <= $urandom;
            end
        end
    end

    // Reference: the ordered list of memory operations a run must issue, plus its final verdict.
    typedef struct {
        bit            wr;
        int            addr;
        logic [DW-1:0] data;
    } op_t;

    op_t           ops[$];
    int            m_B;
    int            m_err;
    int            m_faddr;
    logic [DW-1:0] m_fexp;
    logic [DW-1:0] m_fgot;
    bit            m_tmo;
    bit            m_pass;

    task automatic build_run(input logic [DW-1:0] p, input int l, input bit k, input int fa,
                             input logic [DW-1:0] fo, input logic [DW-1:0] fz);
        logic [DW-1:0] rm [N];
        logic [DW-1:0] ex;
        logic [DW-1:0] got;
        logic [DW-1:0] wv;
        int            a;
        ops.delete();
        m_err = 0; m_faddr = 0; m_fexp = '0; m_fgot = '0;
        for (int i = 0; i < N; i++) begin
            ops.push_back('{1'b1, i, p});
            rm[i] = p;
        end
        if (k) begin
            ops.push_back('{1'b0, 0, '0});
            m_tmo = 1'b1; m_pass = 1'b0; m_B = N + 1 + TMO;
            return;
        end
        for (int e = 1; e <= 3; e++) begin
            for (int i = 0; i < N; i++) begin
                a  = (e == 1) ? i : N - 1 - i;
                ex = (e == 2) ? ~p : p;
                ops.push_back('{1'b0, a, '0});
                got = faulty(a, rm[a], fa, fo, fz);
                if (got !== ex) begin
                    if (m_err == 0) begin
                        m_faddr = a; m_fexp = ex; m_fgot = got;
                    end
                    if (m_err < 255) m_err++;
                end
                if (e < 3) begin
                    wv = (e == 1) ? ~p : p;
                    ops.push_back('{1'b1, a, wv});
                    rm[a] = wv;
                end
            end
        end
        m_tmo  = 1'b0;
        m_pass = (m_err == 0);
        m_B    = N + 2 * N * (2 + l) + N * (1 + l);
    endtask

    function automatic bit any_out();
        return |{Wr_En, Rd_En, Address, Data_in, Busy, Done, Pass, Err_Count,
                 Fail_Addr, Fail_Exp, Fail_Got, Timeout_Err};
    endfunction

    // Per-cycle compare against the model, sampled mid-cycle.
    int cyc = 0;
    int s   = 0;
    int B   = 0;
    bit have_run = 1'b0;

    initial begin
        op_t op;
        bit  busy_exp;
        bit  done_exp;
        forever begin
            @(negedge CLK);
            cyc++;
            if (Rst) begin
                have_run = 1'b0;
                ops.delete();
                chk("reset_outputs_zero", any_out(), 0);
            end else begin
                chk("no_wr_rd_overlap", Wr_En && Rd_En, 0);
                if (Wr_En || Rd_En) chk("strobe_addr_range", int'(Address) < N, 1);
                busy_exp = have_run && (cyc > s) && (cyc <= s + B);
                done_exp = have_run && (cyc > s + B);
                chk("busy", Busy, busy_exp);
                chk("done", Done, done_exp);
                if (!have_run) chk("idle_outputs_zero", any_out(), 0);
                if (have_run && cyc == s + 1) begin
                    chk("start_clears", {Err_Count, Fail_Addr, Timeout_Err, Pass}, 0);
                    chk("start_clears_data", {Fail_Exp, Fail_Got}, 0);
                    chk("first_access", {Wr_En, Rd_En, Address}, {1'b1, 1'b0, 5'd0});
                end
                if (Wr_En || Rd_En) begin
                    if (ops.size() == 0) begin
                        chk("unexpected_strobe", {Wr_En, Rd_En, Address}, 0);
                    end else begin
                        op = ops.pop_front();
                        chk("op_kind", Wr_En, op.wr);
                        chk("op_addr", Address, op.addr);
                        if (op.wr) chk("op_wdata", Data_in, op.data);
                    end
                end
                if (busy_exp) chk("timeout_err_while_busy", Timeout_Err, 0);
                if (done_exp) begin
                    chk("pass", Pass, m_pass);
                    chk("err_count", Err_Count, m_err);
                    chk("fail_addr", Fail_Addr, m_faddr);
                    chk("fail_exp", Fail_Exp, m_fexp);
                    chk("fail_got", Fail_Got, m_fgot);
                    chk("timeout_err", Timeout_Err, m_tmo);
                    if (cyc == s + B + 1) chk("ops_left_at_done", ops.size(), 0);
                end
                if (Start && !busy_exp) begin
                    have_run = 1'b1;
                    s        = cyc;
                    build_run(Pattern, lat, kill, f_addr, f_or, f_and);
                    B        = m_B;
                end
            end
        end
    end

    // Stimulus runs at posedge+2 so Start/Pattern are stable for both DUT and compare.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic start_pulse(input logic [DW-1:0] p);
        Pattern = p;
        Start   = 1'b1;
        tick();
        Start   = 1'b0;
    endtask

    task automatic run_wait(input int restart_at, output int n, output int b,
                            output int wr, output int rd);
        n = 1; b = 0; wr = 0; rd = 0;
        while (!Done && n < 5000) begin
            if (Busy)  b++;
            if (Wr_En) wr++;
            if (Rd_En) rd++;
            if (n == restart_at) begin
                Start   = 1'b1;
                Pattern = $urandom;
            end
            tick();
            Start = 1'b0;
            n++;
        end
        chk("done_within_bound", Done, 1);
    endtask

    task automatic idle(input int k, output int st);
        st = 0;
        repeat (k) begin
            if (Wr_En || Rd_En) st++;
            tick();
        end
    endtask

    task automatic mem_all(input logic [DW-1:0] p);
        int bad = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== p) bad++;
        chk("mem_final_pattern", bad, 0);
    endtask

    initial begin
        logic [DW-1:0] p;
        int n, b, wr, rd, st;
        Rst = 1'b1; Start = 1'b0; Pattern = '0;

        build_run(32'hA5A5_5A5A, 1, 1'b0, 0, '0, '0);
        chk("model_busy_len", m_B, 288);
        chk("model_op_count", ops.size(), 192);
        chk("model_clean_err", m_err, 0);
        build_run('0, 1, 1'b0, 7, 32'h1, '0);
        chk("model_sa1_err", m_err, 2);
        chk("model_sa1_addr", m_faddr, 7);
        chk("model_sa1_got", m_fgot, 1);
        build_run('0, 1, 1'b1, 0, '0, '0);
        chk("model_tmo_len", m_B, 48);
        chk("model_tmo_ops", ops.size(), 33);
        ops.delete();

        repeat (3) tick();
        Rst = 1'b0;
        tick();
        chk("reset_state", any_out(), 0);

        // Good memory, L=1
        noise = 1'b1;
        p = 32'hA5A5_5A5A;
        start_pulse(p);
        run_wait(0, n, b, wr, rd);
        chk("good_done_cycle", n, 289);
        chk("good_busy_cycles", b, 288);
        chk("good_pass", Pass, 1);
        chk("good_err_count", Err_Count, 0);
        mem_all(p);
        idle(5, st);

        // Bit 0 stuck-at-1 at address 7
        f_addr = 7; f_or = 32'h1; p = '0;
        start_pulse(p);
        run_wait(0, n, b, wr, rd);
        chk("sa1_pass", Pass, 0);
        chk("sa1_err_count", Err_Count, 2);
        chk("sa1_fail_addr", Fail_Addr, 7);
        chk("sa1_fail_exp", Fail_Exp, 0);
        chk("sa1_fail_got", Fail_Got, 1);
        idle(3, st);

        // Valid_out never returns
        f_or = '0; kill = 1'b1; p = 32'h0F0F_3C3C;
        start_pulse(p);
        run_wait(0, n, b, wr, rd);
        chk("tmo_done_cycle", n, 49);
        chk("tmo_reads", rd, 1);
        chk("tmo_writes", wr, 32);
        chk("tmo_flag", Timeout_Err, 1);
        chk("tmo_pass", Pass, 0);
        idle(10, st);
        chk("tmo_no_more_access", st, 0);
        kill = 1'b0;

        // Start ignored mid-run, then fresh run after Done
        f_addr = 19; f_and = 32'h20; p = '1;
        start_pulse(p);
        run_wait(100, n, b, wr, rd);
        chk("restart_ignored_done_cycle", n, 289);
        chk("sa0_err_count", Err_Count, 2);
        chk("sa0_fail_addr", Fail_Addr, 19);
        chk("sa0_fail_got", Fail_Got, 32'hFFFF_FFDF);
        f_and = '0; p = 32'h1234_5678;
        start_pulse(p);
        chk("fresh_run_cleared", {Err_Count, Fail_Addr, Done}, 0);
        run_wait(0, n, b, wr, rd);
        chk("fresh_run_pass", Pass, 1);

        // Reset in the middle of M2
        p = $urandom;
        start_pulse(p);
        repeat (149) tick();
        Rst = 1'b1;
        #1;
        chk("midrun_reset_outputs", any_out(), 0);
        repeat (3) tick();
        Rst = 1'b0;
        idle(4, st);
        chk("after_reset_no_access", st, 0);
        p = $urandom;
        start_pulse(p);
        run_wait(0, n, b, wr, rd);
        chk("after_reset_done_cycle", n, 289);
        chk("after_reset_pass", Pass, 1);

        // Randomised runs
        for (int r = 0; r < 8; r++) begin
            lat  = $urandom_range(1, 3);
            kill = (r == 5);
            p    = $urandom;
            f_addr = $urandom_range(0, N - 1);
            f_or = '0; f_and = '0;
            case ($urandom_range(0, 2))
                1: f_or  = 32'h1 << $urandom_range(0, DW - 1);
                2: f_and = 32'h1 << $urandom_range(0, DW - 1);
                default: ;
            endcase
            start_pulse(p);
            run_wait($urandom_range(2, 250), n, b, wr, rd);
            if (!kill) mem_all(p);
            idle($urandom_range(1, 4), st);
        end
        kill = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_march_bist.md
# mem_march_bist

Built-in self-test initiator for the 32-location memory: the requester end of the memory port (drives Wr_En/Rd_En/Address/Data_in, consumes Data_out/Valid_out). On a Start pulse it runs a four-element March sequence over every location, compares every read against the expected pattern and reports pass/fail with first-failure capture. It sits between the memory and the test-control logic and replaces the class-based driver when the memory is exercised in-system.

## Interface
- Data_Width, 32, memory word width
- Address_Width, 5, memory address width
- Locations_Num, 32, locations tested (addresses 0..Locations_Num-1; must be ≤ 2^Address_Width)
- Timeout, 15, max cycles waited for Valid_out after a read request
- CLK  in  1  clock, all logic on rising edge
- Rst  in  1  asynchronous, active-high reset (integration inverts it for the memory's Rst_n)
- Start  in  1  one-cycle request to begin a test; ignored while Busy
- Pattern  in  Data_Width  background pattern P, sampled on accepted Start
- Wr_En  out  1  memory write strobe
- Rd_En  out  1  memory read strobe
- Address  out  Address_Width  memory address
- Data_in  out  Data_Width  memory write data
- Data_out  in  Data_Width  memory read data
- Valid_out  in  1  memory read data valid
- Busy  out  1  test in progress
- Done  out  1  test finished; held until next accepted Start
- Pass  out  1  valid when Done: no mismatch and no timeout
- Err_Count  out  8  mismatch count, saturates at 255
- Fail_Addr  out  Address_Width  address of first mismatch
- Fail_Exp  out  Data_Width  expected data of first mismatch
- Fail_Got  out  Data_Width  read data of first mismatch
- Timeout_Err  out  1  a read timed out; test aborted

## Operation
- Sequence (P = latched Pattern, ~P = bitwise inverse): M0 ascending w(P); M1 ascending r(P) w(~P); M2 descending r(~P) w(P); M3 descending r(P). Ascending 0→Locations_Num-1, descending Locations_Num-1→0.
- States: IDLE, WRITE, READ_REQ, READ_WAIT, DONE.
- IDLE: Start=1 → latch Pattern, clear Err_Count/Fail_*/Timeout_Err/Done/Pass, Address=0, element M0, go WRITE.
- WRITE: Wr_En=1 one cycle, Data_in = element's write value. Then advance address/element; next state READ_REQ (M1..M3) or WRITE (M0).
- READ_REQ: Rd_En=1 one cycle, Address held; → READ_WAIT, wait counter cleared.
- READ_WAIT: Valid_out=1 → compare Data_out with expected; mismatch increments Err_Count (saturating) and, if first, captures Fail_Addr/Fail_Exp/Fail_Got. Then → WRITE (M1, M2) or advance address (M3). Valid_out absent for Timeout cycles → Timeout_Err=1, → DONE.
- Advance: last address of an element moves to first address of next element; last address of M3 → DONE.
- DONE: Busy=0, Done=1, Pass = (Err_Count==0) && !Timeout_Err; Start restarts from IDLE behaviour.
- Wr_En and Rd_En never high in the same cycle; Valid_out outside READ_WAIT ignored; Start while Busy ignored.

## Timing
- Reset (any time, including mid-test): state IDLE, every output 0; takes effect immediately, no memory access after assertion.
- Start sampled in cycle 0; first access (M0 write, address 0) in cycle 1; Busy high from cycle 1.
- Per address: M0 1 cycle; M1/M2 2+L cycles; M3 1+L cycles, L = read latency (cycles from Rd_En to Valid_out, ≥1).
- With L=1 and Locations_Num=32: Busy high exactly 32+96+96+64 = 288 cycles; Done=1 and Busy=0 from cycle 289.
- Fail_*/Err_Count update on the edge after Valid_out is seen; Pass valid in the same cycle Done rises.
- Timeout: Timeout_Err and Done rise Timeout+1 cycles after the Rd_En cycle.

## Test plan
- Good memory, L=1, Pattern=32'hA5A5_5A5A, Start pulse → Busy 288 cycles, Done=1, Pass=1, Err_Count=0, memory ends holding A5A5_5A5A everywhere.
- Memory model forcing bit 0 stuck-at-1 at address 7, Pattern=0 → Pass=0, Err_Count=2 (M1 r(P) and M3 r(P)), Fail_Addr=7, Fail_Exp=0, Fail_Got=1.
- Valid_out tied 0, Start → one Rd_En at address 0 in M1, Timeout_Err=1 and Done=1 16 cycles later, Pass=0, no further Wr_En/Rd_En.
- Start pulsed again at cycle 100 of a running test → ignored, completion still at cycle 289; Start after Done → fresh run, Err_Count/Fail_* cleared.
- Rst asserted during M2 → all outputs 0 immediately, state IDLE; subsequent Start runs full 288-cycle test with Pass=1.
- Per-cycle assertion over all runs: never Wr_En && Rd_En; Address < Locations_Num whenever a strobe is high.
